// File: rtl/ber_pkg.sv
// rtl/ber_pkg.sv - shared state type and PRBS tap table for the BER monitor
package ber_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } ber_state_t;

    // Second feedback tap of the x^N + x^TAP + 1 generator; 0 marks an unsupported order.
    function automatic int prbs_tap(input int order);
        case (order)
            7:       return 6;
            9:       return 5;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return 0;
        endcase
    endfunction

    function automatic bit prbs_order_legal(input int order);
        return prbs_tap(order) != 0;
    endfunction

endpackage

// File: rtl/prbs_predictor.sv
// rtl/prbs_predictor.sv - PRBS shift register, either seeded from the input bit or free-running
module prbs_predictor #(
    parameter int ORDER = 7,
    parameter int TAP   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_load,
    input  logic i_bit,
    output logic o_pred,
    output logic o_next_nz
);

    logic [ORDER-1:0] r_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
        end else if (i_en) begin
            r_s <= {r_s[ORDER-2:0], i_load ? i_bit : o_pred};
        end
    end

    assign o_pred    = r_s[ORDER-1] ^ r_s[TAP-1];
    // Register contents after loading i_bit are non-zero (a valid seed).
    assign o_next_nz = |{r_s[ORDER-2:0], i_bit};

endmodule

// File: rtl/prbs_ber_monitor.sv
// rtl/prbs_ber_monitor.sv - self-synchronising PRBS bit-error-rate monitor
module prbs_ber_monitor
    import ber_pkg::*;
#(
    parameter int PRBS_ORDER  = 7,
    parameter int WIN_LOG2    = 10,
    parameter int CNT_W       = 32,
    parameter int LOSS_THRESH = 2**(WIN_LOG2-3),
    parameter int SYNC_MATCH  = 2*PRBS_ORDER
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                bit_en,
    input  logic                rx_bit,
    input  logic                clr,
    output logic                locked,
    output logic                err_pulse,
    output logic                win_done,
    output logic [WIN_LOG2:0]   win_err,
    output logic [CNT_W-1:0]    bit_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int SEED_W = $clog2(PRBS_ORDER+1);
    localparam int MATCH_W = $clog2(SYNC_MATCH+1);
    localparam logic [WIN_LOG2:0] LOSS_LIM = (WIN_LOG2+1)'(LOSS_THRESH);

    if (!prbs_order_legal(PRBS_ORDER)) begin : g_bad_order
        $error("prbs_ber_monitor: PRBS_ORDER must be 7, 9, 15, 23 or 31");
    end

    ber_state_t           r_state;
    ber_state_t           w_state_nx;
    logic [SEED_W-1:0]    r_seed;
    logic [MATCH_W-1:0]   r_match;
    logic [WIN_LOG2-1:0]  r_win_bits;
    logic [WIN_LOG2:0]    r_win_errs;
    logic [WIN_LOG2:0]    w_win_err_nx;
    logic                 w_pred;
    logic                 w_next_nz;
    logic                 w_load;
    logic                 w_mismatch;
    logic                 w_count;
    logic                 w_win_last;
    logic                 w_seed_full;
    logic                 w_match_full;
    logic                 w_lock_entry;

    assign w_mismatch   = rx_bit ^ w_pred;
    // A mismatch in CHECK reseeds from the offending bit instead of the prediction.
    assign w_load       = (r_state == HUNT) || ((r_state == CHECK) && w_mismatch);
    assign w_count      = bit_en && (r_state == LOCKED) && !clr;
    assign w_win_last   = w_count && (&r_win_bits);
    assign w_win_err_nx = r_win_errs + {{WIN_LOG2{1'b0}}, w_mismatch};
    assign w_seed_full  = (r_seed == SEED_W'(PRBS_ORDER-1));
    assign w_match_full = (r_match == MATCH_W'(SYNC_MATCH-1));
    assign w_lock_entry = (r_state == CHECK) && (w_state_nx == LOCKED);

    prbs_predictor #(
        .ORDER (PRBS_ORDER),
        .TAP   (prbs_tap(PRBS_ORDER))
    ) u_pred (
        .clk       (sys_clk),
        .rst_n     (reset),
        .i_en      (bit_en),
        .i_load    (w_load),
        .i_bit     (rx_bit),
        .o_pred    (w_pred),
        .o_next_nz (w_next_nz)
    );

    always_comb begin
        w_state_nx = r_state;
        if (bit_en) begin
            case (r_state)
                HUNT:    if (w_seed_full && w_next_nz) w_state_nx = CHECK;
                CHECK:   if (w_mismatch)               w_state_nx = HUNT;
                         else if (w_match_full)        w_state_nx = LOCKED;
                LOCKED:  if (w_win_last && (w_win_err_nx > LOSS_LIM)) w_state_nx = HUNT;
                default: w_state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
            locked  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            locked  <= (w_state_nx == LOCKED);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_seed  <= '0;
            r_match <= '0;
        end else if (bit_en) begin
            case (r_state)
                HUNT: begin
                    r_match <= '0;
                    r_seed  <= w_seed_full ? '0 : r_seed + 1'b1;
                end
                CHECK: begin
                    if (w_mismatch) r_seed  <= SEED_W'(1);
                    else            r_match <= r_match + 1'b1;
                end
                default: r_seed <= '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            err_pulse  <= 1'b0;
            win_done   <= 1'b0;
            win_err    <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            r_win_bits <= '0;
            r_win_errs <= '0;
        end else begin
            err_pulse <= 1'b0;
            win_done  <= 1'b0;
            if (clr) begin
                win_err    <= '0;
                bit_cnt    <= '0;
                err_cnt    <= '0;
                r_win_bits <= '0;
                r_win_errs <= '0;
            end else if (bit_en && w_lock_entry) begin
                r_win_bits <= '0;
                r_win_errs <= '0;
            end else if (w_count) begin
                if (!(&bit_cnt)) bit_cnt <= bit_cnt + 1'b1;
                if (w_mismatch) begin
                    err_pulse <= 1'b1;
                    if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                end
                r_win_bits <= r_win_bits + 1'b1;
                if (w_win_last) begin
                    win_err    <= w_win_err_nx;
                    win_done   <= 1'b1;
                    r_win_errs <= '0;
                end else begin
                    r_win_errs <= w_win_err_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_ber_monitor.sv
// tb/tb_prbs_ber_monitor.sv - self-checking bench for prbs_ber_monitor
module tb_prbs_ber_monitor;

    localparam int W  = 7;
    localparam int CW = 8;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          bit_en;
    logic          rx_bit;
    logic          clr;
    logic          locked;
    logic          err_pulse;
    logic          win_done;
    logic [W:0]    win_err;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] err_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_on   = 0;
    bit gen[127];
    int n_pos    = 0;
    int n_pulses = 0;

    int m_mode, m_seeds, m_matches, m_wbits, m_werrs;
    int m_bits, m_errs, m_win_err;
    bit m_pulse, m_done;
    bit hist[$];

    always #5 sys_clk = ~sys_clk;

    prbs_ber_monitor #(
        .PRBS_ORDER  (7),
        .WIN_LOG2    (W),
        .CNT_W       (CW),
        .LOSS_THRESH (16)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .rx_bit    (rx_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .win_done  (win_done),
        .win_err   (win_err),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_seeds = 0; m_matches = 0; m_wbits = 0; m_werrs = 0;
        m_bits = 0; m_errs = 0; m_win_err = 0; m_pulse = 0; m_done = 0;
        hist = '{0, 0, 0, 0, 0, 0, 0};
    endtask

    // hist holds the last 7 local-sequence bits, oldest first: prediction is b[n-7]^b[n-6].
    task automatic model_step();
        bit pred, mism, nz;
        m_pulse = 0;
        m_done  = 0;
        if (clr) begin
            m_bits = 0; m_errs = 0; m_win_err = 0; m_wbits = 0; m_werrs = 0;
        end
        if (bit_en) begin
            pred = hist[0] ^ hist[1];
            mism = (rx_bit != pred);
            void'(hist.pop_front());
            if (m_mode == 0) begin
                hist.push_back(rx_bit);
                m_seeds++;
                if (m_seeds == 7) begin
                    m_seeds = 0;
                    nz = 0;
                    foreach (hist[i]) nz |= hist[i];
                    if (nz) begin
                        m_mode = 1;
                        m_matches = 0;
                    end
                end
            end else if (m_mode == 1) begin
                if (!mism) begin
                    hist.push_back(pred);
                    m_matches++;
                    if (m_matches == 14) begin
                        m_mode = 2; m_wbits = 0; m_werrs = 0;
                    end
                end else begin
                    hist.push_back(rx_bit);
                    m_mode = 0;
                    m_seeds = 1;
                end
            end else begin
                hist.push_back(pred);
                if (!clr) begin
                    if (m_bits < 255) m_bits++;
                    m_wbits++;
                    if (mism) begin
                        if (m_errs < 255) m_errs++;
                        m_werrs++;
                        m_pulse = 1;
                    end
                    if (m_wbits == 128) begin
                        m_win_err = m_werrs;
                        m_done = 1;
                        if (m_werrs > 16) begin
                            m_mode = 0;
                            m_seeds = 0;
                        end
                        m_wbits = 0;
                        m_werrs = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_on) begin
                check("locked",    locked,    longint'(m_mode == 2));
                check("err_pulse", err_pulse, m_pulse);
                check("win_done",  win_done,  m_done);
                check("win_err",   win_err,   m_win_err);
                check("bit_cnt",   bit_cnt,   m_bits);
                check("err_cnt",   err_cnt,   m_errs);
                if (err_pulse) n_pulses++;
            end
        end
    end

    // Called at a negedge; leaves bit_en high across exactly one rising edge.
    task automatic strobe(input bit b, input bit c, input int gap);
        bit_en = 1'b1;
        rx_bit = b;
        clr    = c;
        @(negedge sys_clk);
        bit_en = 1'b0;
        clr    = 1'b0;
        repeat (gap-1) @(negedge sys_clk);
    endtask

    task automatic send(input bit flip, input bit c, input int gap);
        strobe(gen[n_pos % 127] ^ flip, c, gap);
        n_pos++;
    endtask

    task automatic lock21(input string tag, input int gap);
        for (int i = 0; i < 20; i++) send(0, 0, gap);
        check({tag, "_unlocked_at_20"}, locked, 0);
        send(0, 0, gap);
        check({tag, "_locked_at_21"}, locked, 1);
    endtask

    initial begin
        int p0;
        bit seen_lock;
        for (int i = 0; i < 7; i++) gen[i] = (i == 0);
        for (int i = 7; i < 127; i++) gen[i] = gen[i-7] ^ gen[i-6];

        reset = 1'b0; bit_en = 1'b0; rx_bit = 1'b0; clr = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_on = 1;
        check("reset_locked", locked, 0);
        check("reset_bit_cnt", bit_cnt, 0);
        reset = 1'b1;
        @(negedge sys_clk);

        seen_lock = 0;
        for (int i = 0; i < 500; i++) begin
            strobe(1'b0, 1'b0, 1);
            seen_lock |= locked;
        end
        check("zeros_never_locked", seen_lock, 0);
        check("zeros_bit_cnt", bit_cnt, 0);
        check("zeros_err_cnt", err_cnt, 0);

        reset = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);

        n_pos = 37;
        lock21("clean", 4);
        for (int i = 0; i < 128; i++) send(0, 0, 4);
        check("clean_bit_cnt", bit_cnt, 128);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_win_err", win_err, 0);

        p0 = n_pulses;
        for (int i = 0; i < 128; i++) send((i % 32) == 31, 0, 1);
        check("sparse_win_err", win_err, 4);
        check("sparse_pulses", n_pulses - p0, 4);
        check("sparse_locked", locked, 1);
        check("sparse_err_cnt", err_cnt, 4);
        check("sparse_bit_cnt_sat", bit_cnt, 255);

        for (int i = 0; i < 128; i++) send((i >= 10) && (i < 30), 0, 1);
        check("burst_win_err", win_err, 20);
        check("burst_unlocked", locked, 0);
        check("burst_err_cnt", err_cnt, 24);
        lock21("relock", 1);

        send(0, 1, 1);
        check("clr_bit_cnt", bit_cnt, 0);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_locked", locked, 1);
        for (int i = 0; i < 300; i++) send((i == 5) || (i == 200), 0, 1);
        check("sat_bit_cnt", bit_cnt, 255);
        check("sat_err_cnt", err_cnt, 2);
        check("sat_win_err", win_err, 1);
        send(1, 1, 1);
        check("clrmis_bit_cnt", bit_cnt, 0);
        check("clrmis_err_cnt", err_cnt, 0);
        check("clrmis_win_err", win_err, 0);
        check("clrmis_err_pulse", err_pulse, 0);
        check("clrmis_locked", locked, 1);

        for (int i = 0; i < 5; i++) send(0, 0, 1);
        check("pre_reset_bit_cnt", bit_cnt, 5);
        #1 reset = 1'b0;
        #1;
        check("async_locked", locked, 0);
        check("async_bit_cnt", bit_cnt, 0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b1;
        lock21("post_reset", 2);

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
